tlb_mmu: RTL

//  Parametrised fully-associative MIPS32-style TLB; successor to the fixed 16-entry translation block.

---
 rtl/tlb_mmu.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/tlb_mmu.sv
// tlb_mmu: fully-associative MIPS32-style TLB with a registered lookup port and a CP0 command port.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   lk_req/vaddr/asid/store      lookup request (sampled each edge)
//   lk_valid/hit/paddr/uncached  registered lookup response, one cycle after lk_req
//   lk_refill/invalid/modified   fault flags; exactly one of hit/faults per valid response
//   cmd_valid/op/index/entryhi/entrylo0/entrylo1
//                                TLBWI(00) TLBWR(01) TLBP(10) TLBR(11)
//   wired_we/wired_val           Wired register write
//   random_o                     Random register
//   cmd_done, probe_o, rd_*      command completion and TLBP/TLBR results
module tlb_mmu #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4,
    parameter int ASID_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lk_req,
    input  logic [31:0]       lk_vaddr,
    input  logic [ASID_W-1:0] lk_asid,
    input  logic              lk_store,
    output logic              lk_valid,
    output logic              lk_hit,
    output logic [31:0]       lk_paddr,
    output logic              lk_uncached,
    output logic              lk_refill,
    output logic              lk_invalid,
    output logic              lk_modified,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd_op,
    input  logic [IDX_W-1:0]  cmd_index,
    input  logic [31:0]       cmd_entryhi,
    input  logic [31:0]       cmd_entrylo0,
    input  logic [31:0]       cmd_entrylo1,
    input  logic              wired_we,
    input  logic [IDX_W-1:0]  wired_val,
    output logic [IDX_W-1:0]  random_o,
    output logic              cmd_done,
    output logic [31:0]       probe_o,
    output logic [31:0]       rd_entryhi,
    output logic [31:0]       rd_entrylo0,
    output logic [31:0]       rd_entrylo1
);
    localparam int MAXI = ENTRIES - 1;
    localparam logic [IDX_W-1:0] TOP = IDX_W'(MAXI);

    // Per-page payload is {PFN[19:0], C[2:0], D, V}
    logic              e_val  [ENTRIES];
    logic [18:0]       e_vpn2 [ENTRIES];
    logic [ASID_W-1:0] e_asid [ENTRIES];
    logic              e_g    [ENTRIES];
    logic [24:0]       e_lo0  [ENTRIES];
    logic [24:0]       e_lo1  [ENTRIES];
    logic [IDX_W-1:0]  wired;

    // Returns {found, index}; scanning downward leaves the lowest matching index
    function automatic logic [IDX_W:0] find(input logic [18:0] vpn, input logic [ASID_W-1:0] asid);
        find = '0;
        for (int i = ENTRIES - 1; i >= 0; i--)
            if (e_val[i] && e_vpn2[i] == vpn && (e_g[i] || e_asid[i] == asid))
                find = {1'b1, IDX_W'(i)};
    endfunction

    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W:0]    lk_m;
    logic [IDX_W:0]    pr_m;
    logic [24:0]       pg;
    logic              unmapped;
    logic              n_hit;
    logic              n_refill;
    logic              n_invalid;
    logic              n_modified;
    logic              n_unc;
    logic [31:0]       n_paddr;
    logic              unused_ok;

    assign unused_ok = ^{cmd_entryhi[12:ASID_W], cmd_entrylo0[31:26], cmd_entrylo1[31:26]};
    assign wr_en     = cmd_valid && !cmd_op[1];
    assign wr_idx    = cmd_op[0] ? random_o : cmd_index;

    always_comb begin
        lk_m       = find(lk_vaddr[31:13], lk_asid);
        pr_m       = find(cmd_entryhi[31:13], cmd_entryhi[ASID_W-1:0]);
        pg         = lk_vaddr[12] ? e_lo1[lk_m[IDX_W-1:0]] : e_lo0[lk_m[IDX_W-1:0]];
        unmapped   = lk_vaddr[31:30] == 2'b10;
        n_refill   = !unmapped && !lk_m[IDX_W];
        n_invalid  = !unmapped && lk_m[IDX_W] && !pg[0];
        n_modified = !unmapped && lk_m[IDX_W] && pg[0] && lk_store && !pg[1];
        n_hit      = unmapped || (lk_m[IDX_W] && pg[0] && !(lk_store && !pg[1]));
        n_unc      = unmapped ? lk_vaddr[29] : (n_hit && pg[4:2] == 3'd2);
        n_paddr    = unmapped ? {3'b000, lk_vaddr[28:0]} : (n_hit ? {pg[24:5], lk_vaddr[11:0]} : 32'h0);
    end

    always_ff @(posedge clk) begin
        if (rst)
            for (int i = 0; i < ENTRIES; i++) e_val[i] <= 1'b0;
        else if (wr_en)
            e_val[wr_idx] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            e_vpn2[wr_idx] <= cmd_entryhi[31:13];
            e_asid[wr_idx] <= cmd_entryhi[ASID_W-1:0];
            e_g[wr_idx]    <= cmd_entrylo0[0] & cmd_entrylo1[0];
            e_lo0[wr_idx]  <= cmd_entrylo0[25:1];
            e_lo1[wr_idx]  <= cmd_entrylo1[25:1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lk_valid    <= 1'b0;
            lk_hit      <= 1'b0;
            lk_paddr    <= '0;
            lk_uncached <= 1'b0;
            lk_refill   <= 1'b0;
            lk_invalid  <= 1'b0;
            lk_modified <= 1'b0;
        end else begin
            lk_valid    <= lk_req;
            lk_hit      <= lk_req && n_hit;
            lk_paddr    <= lk_req ? n_paddr : 32'h0;
            lk_uncached <= lk_req && n_unc;
            lk_refill   <= lk_req && n_refill;
            lk_invalid  <= lk_req && n_invalid;
            lk_modified <= lk_req && n_modified;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_done    <= 1'b0;
            probe_o     <= '0;
            rd_entryhi  <= '0;
            rd_entrylo0 <= '0;
            rd_entrylo1 <= '0;
        end else begin
            cmd_done <= cmd_valid;
            if (cmd_valid && cmd_op == 2'b10)
                probe_o <= pr_m[IDX_W] ? {(32 - IDX_W)'(0), pr_m[IDX_W-1:0]} : 32'h8000_0000;
            if (cmd_valid && cmd_op == 2'b11) begin
                rd_entryhi  <= {e_vpn2[cmd_index], 13'(e_asid[cmd_index])};
                rd_entrylo0 <= {6'b0, e_lo0[cmd_index], e_g[cmd_index]};
                rd_entrylo1 <= {6'b0, e_lo1[cmd_index], e_g[cmd_index]};
            end
        end
    end

    // Random counts down through [wired, ENTRIES-1], reloading whenever it reaches wired
    always_ff @(posedge clk) begin
        if (rst) begin
            random_o <= TOP;
            wired    <= '0;
        end else if (wired_we) begin
            random_o <= TOP;
            wired    <= (int'(wired_val) > MAXI) ? TOP : wired_val;
        end else begin
            random_o <= (random_o <= wired) ? TOP : random_o - IDX_W'(1);
        end
    end
endmodule
